// File: rtl/judge_pkg.sv
// judge_pkg: lane FSM states, default judging windows/points and a 4-bit saturating adder.
package judge_pkg;
  typedef enum logic [1:0] {IDLE, POP, HOLDOFF} lane_state_t;
  localparam logic [9:0] TARGET_Y_DEF = 10'd40;
  localparam int PERFECT_WIN_DEF = 4;
  localparam int GOOD_WIN_DEF = 12;
  localparam int PERFECT_PTS_DEF = 3;
  localparam int GOOD_PTS_DEF = 1;
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hf : s[3:0];
  endfunction
endpackage

// File: rtl/lane_judge_array_if.sv
// lane_judge_array_if: note engine / keyboard inputs and score outputs; combo exists only with JUDGE_COMBO_EN.
interface lane_judge_array_if;
  logic frame_clk;
  logic [3:0] key, note_valid, note_pop;
  logic [9:0] note_y0, note_y1, note_y2, note_y3;
  logic [3:0] hit0, hit1, hit2, hit3;
  logic [3:0] miss0, miss1, miss2, miss3;
`ifdef JUDGE_COMBO_EN
  logic [7:0] combo;
`endif
  modport master(
`ifdef JUDGE_COMBO_EN
    input combo,
`endif
    output frame_clk, key, note_valid, note_y0, note_y1, note_y2, note_y3,
    input note_pop, hit0, hit1, hit2, hit3, miss0, miss1, miss2, miss3
  );
  modport slave(
`ifdef JUDGE_COMBO_EN
    output combo,
`endif
    input frame_clk, key, note_valid, note_y0, note_y1, note_y2, note_y3,
    output note_pop, hit0, hit1, hit2, hit3, miss0, miss1, miss2, miss3
  );
endinterface

// File: rtl/lane_judge.sv
// lane_judge: one lane's press edge detect, judging FSM and per-frame hit/miss accumulators.
// JUDGE_COMBO_EN adds the bonus input and per-cycle hit/miss event outputs.
module lane_judge
  import judge_pkg::*;
#(
  parameter logic [9:0] TARGET_Y = TARGET_Y_DEF,
  parameter int PERFECT_WIN = PERFECT_WIN_DEF,
  parameter int GOOD_WIN = GOOD_WIN_DEF,
  parameter int PERFECT_PTS = PERFECT_PTS_DEF,
  parameter int GOOD_PTS = GOOD_PTS_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       frame_edge,
`ifdef JUDGE_COMBO_EN
  input  logic       bonus,
  output logic       hit_ev,
  output logic       miss_ev,
`endif
  input  logic       key,
  input  logic       note_valid,
  input  logic [9:0] note_y,
  output logic       note_pop,
  output logic [3:0] hit,
  output logic [3:0] miss
);
`ifndef JUDGE_COMBO_EN
  logic hit_ev, miss_ev, bonus;
  assign bonus = 1'b0;
`endif
  lane_state_t state;
  logic key_d, press, idle, in_perfect, in_good, passed;
  logic [3:0] hit_acc, miss_acc, pts, hit_nx, miss_nx;
  logic [10:0] diff, mag;
  // diff is two's complement; bit 10 set means the note is above the receptor
  assign diff = {1'b0, note_y} - {1'b0, TARGET_Y};
  assign mag = diff[10] ? -diff : diff;
  assign press = key & ~key_d;
  assign idle = state == IDLE;
  assign in_perfect = note_valid && mag <= 11'(PERFECT_WIN);
  assign in_good = note_valid && mag <= 11'(GOOD_WIN);
  assign passed = note_valid && diff[10] && mag > 11'(GOOD_WIN);
  assign miss_ev = idle && (passed || (press && !in_good));
  assign hit_ev = idle && !passed && press && in_good;
  assign pts = sat_add4(in_perfect ? 4'(PERFECT_PTS) : 4'(GOOD_PTS), {3'b0, bonus});
  assign hit_nx = sat_add4(hit_acc, hit_ev ? pts : 4'd0);
  assign miss_nx = sat_add4(miss_acc, {3'b0, miss_ev});
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
      key_d <= 1'b0;
      note_pop <= 1'b0;
      hit_acc <= '0;
      miss_acc <= '0;
      hit <= '0;
      miss <= '0;
    end else begin
      key_d <= key;
      state <= idle ? ((hit_ev || passed) ? POP : IDLE) : (state == POP ? HOLDOFF : IDLE);
      note_pop <= idle && (hit_ev || passed);
      hit_acc <= frame_edge ? 4'd0 : hit_nx;
      miss_acc <= frame_edge ? 4'd0 : miss_nx;
      if (frame_edge) begin
        hit <= hit_nx;
        miss <= miss_nx;
      end
    end
  end
endmodule

// File: rtl/lane_judge_array.sv
// lane_judge_array: four independent lane judges sharing one frame edge detector.
// JUDGE_COMBO_EN adds the cross-lane combo counter and its hit bonus.
module lane_judge_array
  import judge_pkg::*;
#(
  parameter logic [9:0] TARGET_Y = TARGET_Y_DEF,
  parameter int PERFECT_WIN = PERFECT_WIN_DEF,
  parameter int GOOD_WIN = GOOD_WIN_DEF,
  parameter int PERFECT_PTS = PERFECT_PTS_DEF,
  parameter int GOOD_PTS = GOOD_PTS_DEF
) (
  input logic Clk,
  input logic reset,
  lane_judge_array_if.slave bus
);
  logic frame_clk_d, frame_edge;
  logic [3:0] pop;
  logic [9:0] note_y [4];
  logic [3:0] hit [4];
  logic [3:0] miss [4];
  assign frame_edge = bus.frame_clk & ~frame_clk_d;
  assign note_y[0] = bus.note_y0;
  assign note_y[1] = bus.note_y1;
  assign note_y[2] = bus.note_y2;
  assign note_y[3] = bus.note_y3;
  assign bus.note_pop = pop;
  assign {bus.hit0, bus.hit1, bus.hit2, bus.hit3} = {hit[0], hit[1], hit[2], hit[3]};
  assign {bus.miss0, bus.miss1, bus.miss2, bus.miss3} = {miss[0], miss[1], miss[2], miss[3]};
  always_ff @(posedge Clk) frame_clk_d <= reset ? 1'b0 : bus.frame_clk;
`ifdef JUDGE_COMBO_EN
  logic [3:0] hit_ev, miss_ev;
  logic [7:0] combo;
  logic [8:0] combo_sum;
  logic bonus;
  assign combo_sum = {1'b0, combo} + 9'($countones(hit_ev));
  assign bonus = combo >= 8'd10;
  assign bus.combo = combo;
  // any miss in the cycle wins over same-cycle hits
  always_ff @(posedge Clk)
    combo <= reset || |miss_ev ? 8'd0 : (combo_sum[8] ? 8'hff : combo_sum[7:0]);
`endif
  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_judge #(
      .TARGET_Y(TARGET_Y), .PERFECT_WIN(PERFECT_WIN), .GOOD_WIN(GOOD_WIN),
      .PERFECT_PTS(PERFECT_PTS), .GOOD_PTS(GOOD_PTS)
    ) u_lane (
      .Clk(Clk),
      .reset(reset),
      .frame_edge(frame_edge),
`ifdef JUDGE_COMBO_EN
      .bonus(bonus),
      .hit_ev(hit_ev[i]),
      .miss_ev(miss_ev[i]),
`endif
      .key(bus.key[i]),
      .note_valid(bus.note_valid[i]),
      .note_y(note_y[i]),
      .note_pop(pop[i]),
      .hit(hit[i]),
      .miss(miss[i])
    );
  end
endmodule
